// File: rtl/turn_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_scheduler: buffers key events and issues only the active player's   |
// | commands to the game logic, rotating players on end-turn or timer expiry.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module turn_scheduler #(
  parameter int PLAYER_NUM   = 2,
  parameter int PLAYER_WIDTH = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int TURN_FRAMES  = 150,
  parameter int FRAME_WIDTH  = 8
) (
  input  logic                    clk_vga,
  input  logic                    reset_n,
  input  logic                    keyboard_locker,
  input  logic [2:0]              keyboard_data,
  input  logic                    vsync_tick,
  input  logic                    game_over,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_code,
  output logic [PLAYER_WIDTH-1:0] cmd_player,
  output logic [PLAYER_WIDTH-1:0] cur_player,
  output logic [FRAME_WIDTH-1:0]  turn_timer,
  output logic                    turn_start,
  output logic                    overflow,
  output logic                    halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]            FULL_CNT    = FIFO_DEPTH[PTR_W:0];
  localparam logic [PLAYER_WIDTH-1:0]   LAST_PLAYER = PLAYER_WIDTH'(PLAYER_NUM - 1);
  localparam logic [FRAME_WIDTH-1:0]    TIMER_INIT  = FRAME_WIDTH'(TURN_FRAMES);
  localparam logic [2:0]                CODE_END    = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic       locker_s1_q, locker_s2_q, locker_s3_q;
  logic [2:0] data_s1_q, data_s2_q;

  logic [2:0]              mem_q [FIFO_DEPTH];
  logic [2:0]              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          count_q, count_d;

  logic                    cmd_valid_q, cmd_valid_d;
  logic [2:0]              cmd_code_q, cmd_code_d;
  logic [PLAYER_WIDTH-1:0] cur_player_q, cur_player_d;
  logic [FRAME_WIDTH-1:0]  timer_q, timer_d;
  logic                    turn_start_q, turn_start_d;
  logic                    overflow_q, overflow_d;

  logic       key_event, push, pop, accepting;
  logic [2:0] head;

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_code_d   = cmd_code_q;
    cur_player_d = cur_player_q;
    timer_d      = timer_q;
    overflow_d   = overflow_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    push         = 1'b0;
    pop          = 1'b0;
    key_event    = locker_s2_q & ~locker_s3_q;
    head         = mem_q[rd_ptr_q];
    accepting    = (state_q == ST_RUN) || (state_q == ST_ISSUE);
    turn_start_d = (state_q == ST_SWITCH);

    if (accepting && vsync_tick && (timer_q != '0)) begin
      timer_d = timer_q - FRAME_WIDTH'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_HALT;
        end else if (timer_q == '0) begin
          state_d = ST_SWITCH;
        end else if (count_q != '0) begin
          pop = 1'b1;
          if (head == CODE_END) begin
            state_d = ST_SWITCH;
          end else begin
            cmd_code_d  = head;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_SWITCH: begin
        cur_player_d = (cur_player_q == LAST_PLAYER) ? '0 : cur_player_q + PLAYER_WIDTH'(1);
        timer_d      = TIMER_INIT;
        overflow_d   = 1'b0;
        state_d      = ST_RUN;
      end
      default: begin
        cmd_valid_d = 1'b0;
      end
    endcase

    // A full FIFO can still accept when the head leaves on the same edge.
    if (key_event && accepting) begin
      if ((count_q != FULL_CNT) || pop) begin
        push = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = data_s2_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (state_q == ST_SWITCH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      locker_s1_q  <= 1'b0;
      locker_s2_q  <= 1'b0;
      locker_s3_q  <= 1'b0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cur_player_q <= '0;
      timer_q      <= TIMER_INIT;
      turn_start_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      locker_s1_q  <= keyboard_locker;
      locker_s2_q  <= locker_s1_q;
      locker_s3_q  <= locker_s2_q;
      data_s1_q    <= keyboard_data;
      data_s2_q    <= data_s1_q;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cur_player_q <= cur_player_d;
      timer_q      <= timer_d;
      turn_start_q <= turn_start_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_player = cur_player_q;
  assign cur_player = cur_player_q;
  assign turn_timer = timer_q;
  assign turn_start = turn_start_q;
  assign overflow   = overflow_q;
  assign halted     = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_turn_scheduler: directed and random stimulus against a queue model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_turn_scheduler;

  localparam int PN = 2;
  localparam int PW = 2;
  localparam int FD = 4;
  localparam int TF = 5;
  localparam int FW = 8;

  localparam int M_RUN = 0, M_ISS = 1, M_SW = 2, M_HALT = 3;

  logic          clk_vga = 1'b0;
  logic          reset_n = 1'b0;
  logic          keyboard_locker = 1'b0;
  logic [2:0]    keyboard_data = '0;
  logic          vsync_tick = 1'b0;
  logic          game_over = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [2:0]    cmd_code;
  logic [PW-1:0] cmd_player;
  logic [PW-1:0] cur_player;
  logic [FW-1:0] turn_timer;
  logic          turn_start;
  logic          overflow;
  logic          halted;

  turn_scheduler #(
    .PLAYER_NUM  (PN),
    .PLAYER_WIDTH(PW),
    .FIFO_DEPTH  (FD),
    .TURN_FRAMES (TF),
    .FRAME_WIDTH (FW)
  ) dut (
    .clk_vga        (clk_vga),
    .reset_n        (reset_n),
    .keyboard_locker(keyboard_locker),
    .keyboard_data  (keyboard_data),
    .vsync_tick     (vsync_tick),
    .game_over      (game_over),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .cmd_player     (cmd_player),
    .cur_player     (cur_player),
    .turn_timer     (turn_timer),
    .turn_start     (turn_start),
    .overflow       (overflow),
    .halted         (halted)
  );

  always #10 clk_vga = ~clk_vga;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-edge view of the scheduler built on a queue.
  int m_mode, m_valid, m_code, m_player, m_timer, m_ts, m_ovf;
  int m_q[$];
  bit lh[4];
  int dh[4];

  always @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_RUN; m_valid = 0; m_code = 0; m_player = 0;
      m_timer = TF; m_ts = 0; m_ovf = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin lh[i] = 1'b0; dh[i] = 0; end
    end else begin
      bit ev;
      int evd, h, t_old, n_mode;
      // Key event lands on the third edge after the locker is first seen high.
      for (int i = 3; i > 0; i--) begin lh[i] = lh[i-1]; dh[i] = dh[i-1]; end
      lh[0] = keyboard_locker;
      dh[0] = int'(keyboard_data);
      ev    = lh[2] && !lh[3];
      evd   = dh[2];
      t_old = m_timer;
      n_mode = m_mode;
      m_ts  = (m_mode == M_SW) ? 1 : 0;
      if ((m_mode == M_RUN || m_mode == M_ISS) && vsync_tick && t_old > 0) m_timer = t_old - 1;
      case (m_mode)
        M_RUN: begin
          if (game_over) n_mode = M_HALT;
          else if (t_old == 0) n_mode = M_SW;
          else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (h == 7) n_mode = M_SW;
            else begin m_code = h; m_valid = 1; n_mode = M_ISS; end
          end
        end
        M_ISS: if (cmd_ready) begin m_valid = 0; n_mode = M_RUN; end
        M_SW: begin
          m_player = (m_player + 1) % PN;
          m_timer  = TF;
          m_q.delete();
          m_ovf    = 0;
          n_mode   = M_RUN;
        end
        default: ;
      endcase
      if (ev && (m_mode == M_RUN || m_mode == M_ISS)) begin
        if (m_q.size() < FD) m_q.push_back(evd);
        else m_ovf = 1;
      end
      m_mode = n_mode;
    end
  end

  always @(negedge clk_vga) begin
    if (chk_en && reset_n) begin
      check_eq("cmd_valid",  int'(cmd_valid),  m_valid);
      check_eq("cmd_code",   int'(cmd_code),   m_code);
      check_eq("cmd_player", int'(cmd_player), m_player);
      check_eq("cur_player", int'(cur_player), m_player);
      check_eq("turn_timer", int'(turn_timer), m_timer);
      check_eq("turn_start", int'(turn_start), m_ts);
      check_eq("overflow",   int'(overflow),   m_ovf);
      check_eq("halted",     int'(halted),     (m_mode == M_HALT) ? 1 : 0);
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"},  int'(cmd_valid),  0);
    check_eq({tag, "_code"},   int'(cmd_code),   0);
    check_eq({tag, "_player"}, int'(cur_player), 0);
    check_eq({tag, "_timer"},  int'(turn_timer), TF);
    check_eq({tag, "_start"},  int'(turn_start), 0);
    check_eq({tag, "_ovf"},    int'(overflow),   0);
    check_eq({tag, "_halted"}, int'(halted),     0);
  endtask

  task automatic pulse(input int code, input int hi, input int lo);
    keyboard_data   = 3'(code);
    keyboard_locker = 1'b1;
    repeat (hi) @(negedge clk_vga);
    keyboard_locker = 1'b0;
    repeat (lo) @(negedge clk_vga);
  endtask

  task automatic vsync_pulses(input int n);
    repeat (n) begin
      vsync_tick = 1'b1;
      @(negedge clk_vga);
      vsync_tick = 1'b0;
      @(negedge clk_vga);
    end
  endtask

  task automatic rnd_cycles(input int n);
    repeat (n) begin
      @(negedge clk_vga);
      cmd_ready  = ($urandom_range(0, 2) != 0);
      vsync_tick = ($urandom_range(0, 5) == 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk_vga);
    check_reset_vals("rst0");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk_vga);

    // Single key, latency and hold while not ready
    keyboard_data   = 3'd2;
    keyboard_locker = 1'b1;
    @(negedge clk_vga);
    keyboard_locker = 1'b0;
    repeat (2) @(negedge clk_vga);
    check_eq("lat_e3_valid", int'(cmd_valid), 0);
    @(negedge clk_vga);
    check_eq("lat_e4_valid", int'(cmd_valid), 1);
    check_eq("lat_e4_code", int'(cmd_code), 2);
    check_eq("lat_e4_player", int'(cmd_player), 0);
    repeat (5) @(negedge clk_vga);
    check_eq("hold_valid", int'(cmd_valid), 1);
    check_eq("hold_code", int'(cmd_code), 2);
    cmd_ready = 1'b1;
    @(negedge clk_vga);
    check_eq("hs_drop", int'(cmd_valid), 0);
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk_vga);

    // Burst of six keys against a stalled consumer
    for (int c = 0; c < 6; c++) pulse(c, 1, 1);
    repeat (4) @(negedge clk_vga);
    check_eq("burst_ovf", int'(overflow), 1);
    check_eq("burst_head", int'(cmd_code), 0);
    cmd_ready = 1'b1;
    repeat (15) @(negedge clk_vga);
    cmd_ready = 1'b0;

    // End-turn codes
    pulse(7, 1, 1);
    repeat (4) @(negedge clk_vga);
    check_eq("end1_player", int'(cur_player), 1);
    check_eq("end1_timer", int'(turn_timer), TF);
    check_eq("end1_ovf", int'(overflow), 0);
    pulse(7, 1, 1);
    repeat (4) @(negedge clk_vga);
    check_eq("end2_wrap", int'(cur_player), 0);

    // Timer expiry in RUN
    vsync_pulses(TF);
    repeat (3) @(negedge clk_vga);
    check_eq("exp_player", int'(cur_player), 1);
    check_eq("exp_timer", int'(turn_timer), TF);

    // Timer expiry while a command is outstanding
    pulse(1, 1, 1);
    repeat (3) @(negedge clk_vga);
    vsync_pulses(TF);
    repeat (4) @(negedge clk_vga);
    check_eq("exp_iss_player", int'(cur_player), 1);
    check_eq("exp_iss_valid", int'(cmd_valid), 1);
    check_eq("exp_iss_timer", int'(turn_timer), 0);
    cmd_ready = 1'b1;
    @(negedge clk_vga);
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk_vga);
    check_eq("exp_iss_after", int'(cur_player), 0);

    // Random traffic
    repeat (400) begin
      int code;
      code = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
      keyboard_data   = 3'(code);
      keyboard_locker = 1'b1;
      rnd_cycles($urandom_range(1, 3));
      keyboard_locker = 1'b0;
      rnd_cycles($urandom_range(1, 4));
    end
    vsync_tick = 1'b0;
    cmd_ready  = 1'b0;
    repeat (3) @(negedge clk_vga);

    // Game over while issuing, then halt
    pulse(3, 1, 1);
    repeat (6) @(negedge clk_vga);
    game_over = 1'b1;
    repeat (3) @(negedge clk_vga);
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk_vga);
    check_eq("halt_flag", int'(halted), 1);
    check_eq("halt_valid", int'(cmd_valid), 0);
    for (int k = 0; k < 3; k++) begin
      vsync_tick = 1'b1;
      pulse(k + 2, 1, 2);
      vsync_tick = 1'b0;
    end
    repeat (4) @(negedge clk_vga);
    check_eq("halt_stay", int'(halted), 1);

    reset_n = 1'b0;
    repeat (2) @(negedge clk_vga);
    check_reset_vals("rst1");
    game_over = 1'b0;
    cmd_ready = 1'b0;
    reset_n   = 1'b1;
    repeat (4) @(negedge clk_vga);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences keyboard commands into the game logic so that only the active player's commands reach the board datapath.
- Sits between Keyboard_Decoder (locker/data) and Game_Player, in the clk_vga domain.
- Buffers decoded key strobes in a small FIFO and dispatches them over a valid/ready handshake.
- Enforces a per-turn frame timer and rotates the active player.

Parameters:
PLAYER_NUM, 2, number of players in rotation (2..4)
PLAYER_WIDTH, 2, width of player index
FIFO_DEPTH, 4, command FIFO entries (power of 2)
TURN_FRAMES, 150, frames per turn before forced switch
FRAME_WIDTH, 8, width of turn timer (must hold TURN_FRAMES)

Ports:
clk_vga  input  1  game/pixel clock (50 MHz)
reset_n  input  1  asynchronous reset, active-low
keyboard_locker  input  1  key-valid level from Keyboard_Decoder, asynchronous to clk_vga
keyboard_data  input  3  key code, stable while keyboard_locker high
vsync_tick  input  1  one-cycle pulse per frame
game_over  input  1  level from game logic; halts scheduling
cmd_ready  input  1  game logic accepts cmd
cmd_valid  output  1  command offered to game logic
cmd_code  output  3  command code (0 up, 1 down, 2 left, 3 right, 4 select, 5 move, 6 half-move)
cmd_player  output  PLAYER_WIDTH  player issuing cmd (equals cur_player)
cur_player  output  PLAYER_WIDTH  active player
turn_timer  output  FRAME_WIDTH  frames remaining in turn
turn_start  output  1  one-cycle pulse on player switch
overflow  output  1  sticky: key dropped on full FIFO this turn
halted  output  1  scheduler in HALT

Behaviour:
- Reset (async, reset_n=0) values:
  - cmd_valid=0, cmd_code=0, cur_player=0, turn_timer=TURN_FRAMES, turn_start=0, overflow=0, halted=0.
  - FIFO empty; state RUN; synchronisers cleared.
  - Reset mid-handshake drops the pending cmd; the game side must not count it.
- Input capture:
  - keyboard_locker and keyboard_data each pass through a 2-flop synchroniser.
  - Rising edge of synced locker = key event, carrying the synced data.
  - Push occurs on the 3rd clk_vga edge after locker rises.
  - One event per locker pulse; held locker never repeats.
- FIFO:
  - Push when count<FIFO_DEPTH and state!=HALT and state!=SWITCH. Simultaneous push+pop allowed when full (net count unchanged).
  - Push when full and no pop: event dropped, overflow<=1.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - RUN, priority order:
    1. game_over=1 -> HALT.
    2. Else turn_timer==0 -> SWITCH.
    3. Else FIFO non-empty -> pop head. Code 7 (end turn) -> SWITCH with no cmd issued. Other codes -> cmd_code<=head, cmd_valid<=1, next ISSUE.
  - ISSUE:
    - cmd_valid, cmd_code and cmd_player held stable until cmd_valid&&cmd_ready.
    - On that edge cmd_valid<=0, next RUN.
    - game_over and timer expiry are not acted on in ISSUE; they are handled on return to RUN.
    - Minimum cmd spacing is 2 cycles.
  - SWITCH, one cycle:
    - cur_player<=(cur_player==PLAYER_NUM-1)?0:cur_player+1.
    - turn_timer<=TURN_FRAMES; FIFO flushed, including any same-cycle event; overflow<=0.
    - turn_start=1 on the following cycle only; next RUN.
  - HALT: cmd_valid=0, halted=1, no pushes, timer frozen. Exit only via reset.
- Timer:
  - On vsync_tick, decrement if >0 and state is RUN or ISSUE; saturates at 0.
  - vsync_tick in the SWITCH cycle is ignored, since the reload wins.
- Latency: from an empty FIFO in RUN, cmd_valid rises on the edge after the push edge (4th edge after locker rise).
- cmd_player always equals cur_player, because cur_player changes only in SWITCH, never during ISSUE.

Test Plan:
- Reset, then locker pulse with data=2 -> cmd_valid=1, cmd_code=2, cmd_player=0 on 4th edge; with cmd_ready held 0 for 5 cycles, outputs stable; cmd_ready=1 -> cmd_valid=0 next edge.
- cmd_ready=0, 6 key pulses (codes 0..5) -> first popped into ISSUE, next 4 buffered, 6th dropped, overflow=1; then cmd_ready=1 -> codes 0,1,2,3,4 issued in order.
- Key code 7 -> no cmd_valid; cur_player 0->1, turn_start pulse, turn_timer=150, overflow cleared; another code 7 -> cur_player wraps to 0.
- TURN_FRAMES=3, 3 vsync_ticks with no keys -> turn_timer 3,2,1,0 then SWITCH, cur_player=1, turn_timer=3; expiry while in ISSUE -> switch occurs only after handshake completes.
- game_over=1 during ISSUE -> handshake completes, then halted=1; further keys and vsync_ticks cause no change; reset_n low -> all reset values restored.
